// File: rtl/i2c_master_buf.sv
// i2c_master_buf: APB-attached I2C master with DEPTH-byte TX/RX buffers,
// programmable SCL quarter-period divider, open-drain SDA/SCL, per-byte ACK
// checking with NACK abort, master ACK/NACK on reads and a STOP condition.
//
// Ports:
//   clk_i, rstn_i        system clock, asynchronous active-low reset
//   sel_i, enable_i,     APB slave; setup phase = sel_i & ~enable_i, writes and
//   write_i, addr_i,     read capture happen on that edge, ready_o is high in
//   wdata_i, rdata_o,    the following (access) cycle
//   ready_o
//   sda_io, scl_io       open-drain I2C lines (drive 0 or z)
//   irq_o                level interrupt = DONE & IEN
//
// Register map: 0x00 CTRL (GO/RD/IEN), 0x01 STATUS (BUSY/DONE/NACK, W1C 1..2),
//   0x02 NBY, 0x03 ADR, 0x04 DIV, 0x40+i TX[i], 0x80+i RX[i] (read-only).
//
// Optional feature, macro I2C_CLK_STRETCH_EN: when defined, scl_io is
// synchronised and the tick counter holds while a released SCL still reads low
// (slave clock stretching). When undefined, SCL is purely timer driven.
module i2c_master_buf #(
  parameter int DEPTH   = 8,
  parameter int DIV_RST = 25
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sel_i,
  input  logic       enable_i,
  input  logic       write_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       ready_o,
  inout  wire        sda_io,
  inout  wire        scl_io,
  output logic       irq_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {IDLE, START, ADDR, ACK_A, WR, ACK_W, RD, ACK_R, STOP} state_t;

  state_t          state, state_nx;
  logic            busy, done, nack, rd, ien;
  logic [NW-1:0]   nby;
  logic [6:0]      adr;
  logic [7:0]      div;
  logic [7:0]      tx [DEPTH];
  logic [7:0]      rx [DEPTH];
  logic [IW-1:0]   idx;
  logic [1:0]      q;
  logic [2:0]      bitc;
  logic [7:0]      cnt;
  logic [6:0]      rx_sh;
  logic            sda_m, sda_s;
  logic            scl_low_c, sda_low_c;
  logic            scl_low, sda_low_d, sda_low;
  logic            setup, wr_en, rd_en, go, tx_hit, rx_hit;
  logic            hold, tick, end_bit, last;
  logic [7:0]      adr_byte, rd_mux;

  assign busy     = (state != IDLE);
  assign setup    = sel_i & ~enable_i;
  assign wr_en    = setup & write_i;
  assign rd_en    = setup & ~write_i;
  assign go       = wr_en && (addr_i == 8'h00) && wdata_i[0] && !busy;
  assign tx_hit   = (addr_i[7:6] == 2'b01) && (int'(addr_i[5:0]) < DEPTH);
  assign rx_hit   = (addr_i[7:6] == 2'b10) && (int'(addr_i[5:0]) < DEPTH);
  assign adr_byte = {adr, rd};
  assign last     = ((NW'(idx) + NW'(1)) == nby);
  assign irq_o    = done & ien;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_m, scl_s;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      scl_m <= 1'b0;
      scl_s <= 1'b0;
    end else begin
      scl_m <= scl_io;
      scl_s <= scl_m;
    end
  // Released SCL that still reads low is being stretched by a slave. The
  // synchroniser lag also adds a couple of cycles to every high phase.
  assign hold = busy && q[1] && !scl_low_c && !scl_s;
`else
  assign hold = 1'b0;
`endif

  assign tick    = busy && !hold && (cnt == div - 8'd1);
  assign end_bit = tick && (q == 2'd3);

  // Tick generator: one pulse every DIV cycles, only while a transfer runs.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i)               cnt <= '0;
    else if (!busy)            cnt <= '0;
    else if (hold)             cnt <= cnt;
    else if (cnt == div - 8'd1) cnt <= '0;
    else                       cnt <= cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;

  // Next state plus the per-quarter line drive (1 = pull low).
  always_comb begin
    state_nx  = state;
    scl_low_c = 1'b0;
    sda_low_c = 1'b0;
    case (state)
      IDLE:  if (go) state_nx = START;
      START: begin
        sda_low_c = (q != 2'd0);
        scl_low_c = (q == 2'd3);
        if (end_bit) state_nx = ADDR;
      end
      ADDR: begin
        scl_low_c = ~q[1];
        sda_low_c = ~adr_byte[3'd7 - bitc];
        if (end_bit && bitc == 3'd7) state_nx = ACK_A;
      end
      ACK_A: begin
        scl_low_c = ~q[1];
        if (end_bit) state_nx = sda_s ? STOP : (rd ? RD : WR);
      end
      WR: begin
        scl_low_c = ~q[1];
        sda_low_c = ~tx[idx][3'd7 - bitc];
        if (end_bit && bitc == 3'd7) state_nx = ACK_W;
      end
      ACK_W: begin
        scl_low_c = ~q[1];
        if (end_bit) state_nx = (sda_s || last) ? STOP : WR;
      end
      RD: begin
        scl_low_c = ~q[1];
        if (end_bit && bitc == 3'd7) state_nx = ACK_R;
      end
      ACK_R: begin
        scl_low_c = ~q[1];
        sda_low_c = ~last;
        if (end_bit) state_nx = last ? STOP : RD;
      end
      STOP: begin
        scl_low_c = ~q[1];
        sda_low_c = (q != 2'd3);
        if (end_bit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered drive. SDA lags SCL by one clock so data never moves on the
  // same edge SCL falls.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      scl_low   <= 1'b0;
      sda_low_d <= 1'b0;
      sda_low   <= 1'b0;
      sda_m     <= 1'b0;
      sda_s     <= 1'b0;
    end else begin
      scl_low   <= scl_low_c;
      sda_low_d <= sda_low_c;
      sda_low   <= sda_low_d;
      sda_m     <= sda_io;
      sda_s     <= sda_m;
    end

  assign sda_io = sda_low ? 1'b0 : 1'bz;
  assign scl_io = scl_low ? 1'b0 : 1'bz;

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      8'h00:   rd_mux = {5'b0, ien, rd, 1'b0};
      8'h01:   rd_mux = {5'b0, nack, done, busy};
      8'h02:   rd_mux = 8'(nby);
      8'h03:   rd_mux = {1'b0, adr};
      8'h04:   rd_mux = div;
      default: begin
        if (tx_hit)      rd_mux = tx[addr_i[IW-1:0]];
        else if (rx_hit) rd_mux = rx[addr_i[IW-1:0]];
      end
    endcase
  end

  // APB registers and transfer datapath. Engine updates come after the W1C
  // so a DONE/NACK set in the same cycle wins.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      rdata_o <= '0;
      ready_o <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      rd      <= 1'b0;
      ien     <= 1'b0;
      nby     <= NW'(1);  // smallest legal count
      adr     <= '0;
      div     <= 8'(DIV_RST);
      idx     <= '0;
      q       <= '0;
      bitc    <= '0;
      rx_sh   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tx[i] <= '0;
        rx[i] <= '0;
      end
    end else begin
      ready_o <= setup;
      if (rd_en) rdata_o <= rd_mux;
      if (wr_en) begin
        case (addr_i)
          8'h00: begin
            ien <= wdata_i[2];
            if (!busy) rd <= wdata_i[1];
          end
          8'h01: begin
            if (wdata_i[1]) done <= 1'b0;
            if (wdata_i[2]) nack <= 1'b0;
          end
          8'h02: if (!busy && wdata_i != 8'd0 && int'(wdata_i) <= DEPTH) nby <= wdata_i[NW-1:0];
          8'h03: if (!busy) adr <= wdata_i[6:0];
          8'h04: if (!busy) div <= (wdata_i == 8'd0) ? 8'd1 : wdata_i;
          default: if (!busy && tx_hit) tx[addr_i[IW-1:0]] <= wdata_i;
        endcase
      end

      if (go) begin
        done <= 1'b0;
        nack <= 1'b0;
        idx  <= '0;
        q    <= '0;
        bitc <= '0;
      end else begin
        if (tick) q <= q + 2'd1;
        if (end_bit) begin
          case (state)
            ADDR, WR: bitc <= bitc + 3'd1;
            RD: begin
              bitc  <= bitc + 3'd1;
              rx_sh <= {rx_sh[5:0], sda_s};
              if (bitc == 3'd7) rx[idx] <= {rx_sh, sda_s};
            end
            ACK_A: if (sda_s) nack <= 1'b1;
            ACK_W: begin
              if (sda_s)      nack <= 1'b1;
              else if (!last) idx  <= idx + IW'(1);
            end
            ACK_R: if (!last) idx <= idx + IW'(1);
            STOP:  done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
endmodule

// File: tb/tb_i2c_master_buf.sv
// Directed bench for i2c_master_buf: APB register access, write/read
// transfers against a small slave model, address NACK, busy protection,
// NBY/DIV boundary writes and reset in the middle of an address phase.
module tb_i2c_master_buf;
  logic       clk, rstn, sel, en, wr;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       ready, irq;
  wire        sda_w, scl_w;
  logic       sl_low;

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = sl_low ? 1'b0 : 1'bz;

  i2c_master_buf #(.DEPTH(8), .DIV_RST(25)) dut (
    .clk_i(clk), .rstn_i(rstn), .sel_i(sel), .enable_i(en), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
    .sda_io(sda_w), .scl_io(scl_w), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_start = 0, n_stop = 0;
  always @(negedge sda_w) if (scl_w === 1'b1) n_start++;
  always @(posedge sda_w) if (scl_w === 1'b1) n_stop++;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Slave model: acks address and written bytes, returns sl_rd[] on reads
  // and records the master ACK bit after each read byte.
  logic       sl_en = 1'b0;
  int         sl_nby = 1;
  logic [7:0] sl_rd [2];
  logic [7:0] sl_q [$];
  logic [1:0] mack;
  initial begin
    logic [7:0] a, b, d;
    sl_low = 1'b0;
    forever begin
      @(negedge sda_w);
      if (scl_w === 1'b1 && sl_en) begin
        for (int i = 0; i < 8; i++) begin @(posedge scl_w); a = {a[6:0], sda_w}; end
        sl_q.push_back(a);
        @(negedge scl_w); sl_low = 1'b1;
        @(negedge scl_w); sl_low = 1'b0;
        for (int k = 0; k < sl_nby; k++) begin
          if (a[0]) begin
            d = sl_rd[k];
            for (int i = 7; i >= 0; i--) begin
              sl_low = ~d[i];
              @(posedge scl_w); @(negedge scl_w);
            end
            sl_low = 1'b0;
            @(posedge scl_w); mack[k] = sda_w;
            @(negedge scl_w);
          end else begin
            for (int i = 0; i < 8; i++) begin @(posedge scl_w); b = {b[6:0], sda_w}; end
            sl_q.push_back(b);
            @(negedge scl_w); sl_low = 1'b1;
            @(negedge scl_w); sl_low = 1'b0;
          end
        end
      end
    end
  end

  int t_wr;
  task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
    sel = 1'b1; en = 1'b0; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1 t_wr = cyc; en = 1'b1;
    @(posedge clk); #1 sel = 1'b0; en = 1'b0; wr = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [7:0] d, output logic rdy);
    sel = 1'b1; en = 1'b0; wr = 1'b0; addr = a;
    @(posedge clk); #1 d = rdata; rdy = ready; en = 1'b1;
    @(posedge clk); #1 sel = 1'b0; en = 1'b0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 2000) begin @(posedge clk); #1 n++; end
  endtask

  task automatic poll_done();
    logic [7:0] s; logic r; int n;
    n = 0;
    do begin apb_rd(8'h01, s, r); n++; end while (!s[1] && n < 400);
  endtask

  initial begin
    #500000 $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [7:0] v; logic r; int n, s0, t_go;
    rstn = 1'b0; sel = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_sda", sda_w, 1'b1);
    chk("rst_scl", scl_w, 1'b1);
    rstn = 1'b1;
    @(posedge clk); #1;
    apb_rd(8'h01, v, r);
    chk("rst_status", v, 8'h00);
    chk("rd_ready", r, 1'b1);
    chk("ready_drop", ready, 1'b0);
    apb_rd(8'h04, v, r);
    chk("div_rst", v, 8'd25);

    // Write transfer: A0 A5 3C FF, DIV=2, length (2+36)*8 cycles
    apb_wr(8'h04, 8'd2); apb_wr(8'h03, 8'h50); apb_wr(8'h02, 8'd3);
    apb_wr(8'h40, 8'hA5); apb_wr(8'h41, 8'h3C); apb_wr(8'h42, 8'hFF);
    sl_en = 1'b1; sl_nby = 3; sl_q.delete(); s0 = n_stop;
    apb_wr(8'h00, 8'h05); t_go = t_wr;
    wait_irq(n);
    chk("wr_time", cyc - t_go, 304);
    chk("wr_nbytes", sl_q.size(), 4);
    if (sl_q.size() == 4) begin
      chk("wr_b0", sl_q[0], 8'hA0); chk("wr_b1", sl_q[1], 8'hA5);
      chk("wr_b2", sl_q[2], 8'h3C); chk("wr_b3", sl_q[3], 8'hFF);
    end
    chk("wr_stop", n_stop - s0, 1);
    chk("wr_sda_idle", sda_w, 1'b1);
    chk("wr_scl_idle", scl_w, 1'b1);
    apb_rd(8'h01, v, r);
    chk("wr_status", v, 8'h02);
    apb_wr(8'h01, 8'h02);
    apb_rd(8'h01, v, r);
    chk("w1c_status", v, 8'h00);
    chk("w1c_irq", irq, 1'b0);

    // Address NACK: nobody answers, STOP after ACK_A, (2+9)*8 cycles
    sl_en = 1'b0; s0 = n_stop;
    apb_wr(8'h03, 8'h33); apb_wr(8'h02, 8'd1);
    apb_wr(8'h00, 8'h05); t_go = t_wr;
    wait_irq(n);
    chk("nack_time", cyc - t_go, 88);
    chk("nack_irq", irq, 1'b1);
    chk("nack_stop", n_stop - s0, 1);
    apb_rd(8'h01, v, r);
    chk("nack_status", v, 8'h06);
    apb_wr(8'h01, 8'h06);
    chk("nack_irq_clr", irq, 1'b0);

    // Read transfer: 0x5A, 0xC3, master ACK then NACK
    sl_en = 1'b1; sl_nby = 2; sl_q.delete(); mack = 2'b10;
    sl_rd[0] = 8'h5A; sl_rd[1] = 8'hC3;
    apb_wr(8'h03, 8'h21); apb_wr(8'h02, 8'd2);
    apb_wr(8'h00, 8'h03);
    poll_done();
    apb_rd(8'h01, v, r);
    chk("rd_status", v, 8'h02);
    chk("rd_irq_off", irq, 1'b0);
    chk("rd_adr", (sl_q.size() > 0) ? sl_q[0] : 8'h00, 8'h43);
    apb_rd(8'h80, v, r); chk("rd_rx0", v, 8'h5A);
    apb_rd(8'h81, v, r); chk("rd_rx1", v, 8'hC3);
    chk("rd_mack0", mack[0], 1'b0);
    chk("rd_mack1", mack[1], 1'b1);
    apb_wr(8'h01, 8'h02);

    // Busy protection
    sl_nby = 1; sl_q.delete();
    apb_wr(8'h02, 8'd1); apb_wr(8'h03, 8'h50); apb_wr(8'h40, 8'h96);
    s0 = n_start;
    apb_wr(8'h00, 8'h01);
    apb_rd(8'h01, v, r);
    chk("busy_status", v, 8'h01);
    apb_wr(8'h02, 8'd5); apb_wr(8'h00, 8'h01); apb_wr(8'h40, 8'h11);
    poll_done();
    repeat (60) @(posedge clk);
    #1;
    chk("busy_starts", n_start - s0, 1);
    apb_rd(8'h02, v, r); chk("busy_nby", v, 8'd1);
    apb_rd(8'h40, v, r); chk("busy_tx", v, 8'h96);
    chk("busy_bytes", sl_q.size(), 2);
    if (sl_q.size() == 2) chk("busy_data", sl_q[1], 8'h96);
    apb_rd(8'h01, v, r); chk("busy_done", v, 8'h02);
    apb_wr(8'h01, 8'h02);

    // Boundary writes
    apb_wr(8'h02, 8'd0); apb_rd(8'h02, v, r); chk("nby_zero", v, 8'd1);
    apb_wr(8'h02, 8'd9); apb_rd(8'h02, v, r); chk("nby_over", v, 8'd1);
    apb_wr(8'h02, 8'd8); apb_rd(8'h02, v, r); chk("nby_max", v, 8'd8);
    apb_wr(8'h04, 8'd0); apb_rd(8'h04, v, r); chk("div_zero", v, 8'd1);
    apb_wr(8'h10, 8'hFF); apb_rd(8'h10, v, r); chk("unmapped", v, 8'h00);
    apb_rd(8'h88, v, r); chk("rx_oob", v, 8'h00);

    // Reset in the middle of ADDR (address 0x00 write keeps SDA low)
    sl_en = 1'b0;
    apb_wr(8'h04, 8'd2); apb_wr(8'h03, 8'h00); apb_wr(8'h02, 8'd1);
    apb_wr(8'h00, 8'h05);
    repeat (18) @(posedge clk);
    #1 chk("mid_sda_low", sda_w, 1'b0);
    sel = 1'b1; en = 1'b0; wr = 1'b0; addr = 8'h01;
    @(posedge clk); #1;
    chk("mid_ready", ready, 1'b1);
    chk("mid_status", rdata, 8'h01);
    rstn = 1'b0;
    #1;
    chk("mrst_rdata", rdata, 8'h00);
    chk("mrst_ready", ready, 1'b0);
    chk("mrst_sda", sda_w, 1'b1);
    chk("mrst_scl", scl_w, 1'b1);
    chk("mrst_irq", irq, 1'b0);
    sel = 1'b0;
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    apb_rd(8'h01, v, r); chk("mrst_status", v, 8'h00);
    apb_rd(8'h04, v, r); chk("mrst_div", v, 8'd25);
    apb_rd(8'h40, v, r); chk("mrst_tx", v, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
